// File: rtl/tt_um_counter_sweep_ctrl.sv
// Round-robin sweep sequencer that owns a shared up/down counter for two requesters.
// Optional step prescaler enabled by defining SWEEP_PRESCALE_EN.
module tt_um_counter_sweep_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] start_a,
  input  logic [WIDTH-1:0] target_a,
  input  logic             dir_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] start_b,
  input  logic [WIDTH-1:0] target_b,
  input  logic             dir_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             aborted,
  output logic             busy,
  input  logic             abort,
  output logic             ctr_enable,
  output logic             ctr_set,
  output logic [WIDTH-1:0] ctr_set_value,
  output logic             ctr_up_down,
  input  logic [WIDTH-1:0] ctr_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [WIDTH:0] WD_LAST = {1'b0, {WIDTH{1'b1}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] start_q, target_q;
  logic             dir_q;
  logic             owner_q;
  logic             last_b_q;
  logic             aborted_q, aborted_nxt;
  logic [WIDTH:0]   step_q;
  logic             take_a, take_b, accept;
  logic             match;
  logic             tick;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    take_a = req_a && (!req_b || last_b_q);
    take_b = req_b && !take_a;
    accept = (state == IDLE) && (take_a || take_b);
  end

  assign match = (ctr_count == target_q);

`ifdef SWEEP_PRESCALE_EN
  logic [7:0] div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (state != RUN) begin
      div_q <= '0;
    end else if (div_q == 8'(PRESCALE - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign tick = (div_q == 8'd0);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    aborted_nxt   = aborted_q;
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    done_a        = 1'b0;
    done_b        = 1'b0;
    aborted       = 1'b0;
    busy          = 1'b0;
    ctr_enable    = 1'b0;
    ctr_set       = 1'b0;
    ctr_set_value = '0;
    ctr_up_down   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_a || take_b) begin
          state_nxt   = LOAD;
          aborted_nxt = 1'b0;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        gnt_a       = !owner_q;
        gnt_b       = owner_q;
        ctr_up_down = dir_q;
        if (abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else begin
          ctr_set       = 1'b1;
          ctr_set_value = start_q;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        ctr_up_down = dir_q;
        // Abort outranks a match; the watchdog fires on the step that would make 2^WIDTH.
        if (abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else if (match) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b0;
        end else begin
          ctr_enable = tick;
          if (tick && (step_q == WD_LAST)) begin
            state_nxt   = DONE;
            aborted_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done_a    = !owner_q;
        done_b    = owner_q;
        aborted   = aborted_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= aborted_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      owner_q  <= 1'b0;
    end else if (accept) begin
      start_q  <= take_a ? start_a  : start_b;
      target_q <= take_a ? target_a : target_b;
      dir_q    <= take_a ? dir_a    : dir_b;
      owner_q  <= take_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
      step_q   <= '0;
    end else if (state == DONE) begin
      last_b_q <= owner_q;
      step_q   <= '0;
    end else if (ctr_enable) begin
      step_q   <= step_q + 1'b1;
    end
  end

endmodule
